// File: rtl/cpu_sram_arbiter.sv
// cpu_sram_arbiter: shares one SRAM-like port between instruction fetch and
// the memory stage. Each accepted request records its owner in an in-order
// FIFO, and every response is steered back to that owner. Inst responses that
// belong to fetches cancelled by a flush are consumed without being delivered.
// Optional build macro ARB_RR_EN: alternate the grant on inst/data ties
// instead of always favouring data.
module cpu_sram_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    // fetch side
    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,
    output logic [31:0]   inst_rdata,
    input  logic          inst_cancel,
    // memory-stage side
    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [3:0]    data_wstrb,
    input  logic [AW-1:0] data_addr,
    input  logic [31:0]   data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [31:0]   data_rdata,
    // shared memory port
    output logic          req,
    output logic          wr,
    output logic [1:0]    size,
    output logic [3:0]    wstrb,
    output logic [AW-1:0] addr,
    output logic [31:0]   wdata,
    input  logic          addr_ok,
    input  logic          data_ok,
    input  logic [31:0]   rdata,
    output logic          resp_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Owner FIFO: owner bit 1 = data, 0 = inst; discard marks cancelled fetches.
    logic [DEPTH-1:0] owner_q, owner_d;
    logic [DEPTH-1:0] discard_q, discard_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             resp_err_q, resp_err_d;

    logic full, empty, inst_eligible;
    logic gnt_data, gnt_inst;
    logic push, pop;
    logic head_owner, head_discard;

    // Pointer increment that wraps at DEPTH (also correct for DEPTH = 1).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full          = (count_q == CW'(DEPTH));
    assign empty         = (count_q == '0);
    assign inst_eligible = inst_req & ~inst_cancel;

`ifdef ARB_RR_EN
    logic rr_last_q, rr_last_d;

    // Tie goes to the side that did not win the last push; lone requester wins.
    always_comb begin
        gnt_data = data_req & ~full & (~inst_eligible | ~rr_last_q);
        gnt_inst = inst_eligible & ~full & (~data_req | rr_last_q);
    end

    // Remember which side was last pushed so the next tie flips.
    always_comb begin
        rr_last_d = rr_last_q;
        if (push) rr_last_d = gnt_data;
    end

    // Round-robin history register.
    always_ff @(posedge clk) begin
        if (reset) rr_last_q <= 1'b0;
        else       rr_last_q <= rr_last_d;
    end
`else
    // Fixed priority: the memory stage always beats fetch.
    always_comb begin
        gnt_data = data_req & ~full;
        gnt_inst = inst_eligible & ~full & ~data_req;
    end
`endif

    // Drive the shared port from the granted side; all zero when idle.
    always_comb begin
        req   = gnt_data | gnt_inst;
        wr    = 1'b0;
        size  = 2'd0;
        wstrb = 4'd0;
        addr  = '0;
        wdata = 32'd0;
        if (gnt_data) begin
            wr    = data_wr;
            size  = data_size;
            wstrb = data_wstrb;
            addr  = data_addr;
            wdata = data_wdata;
        end else if (gnt_inst) begin
            size  = 2'd2;
            addr  = inst_addr;
        end
    end

    assign data_addr_ok = gnt_data & addr_ok;
    assign inst_addr_ok = gnt_inst & addr_ok;
    assign push         = req & addr_ok;
    assign pop          = data_ok & ~empty;

    assign head_owner   = owner_q[rd_ptr_q];
    assign head_discard = discard_q[rd_ptr_q];

    // Route the response to the head owner. A cancel in the same cycle also
    // kills an inst head, since its discard bit only lands next cycle.
    always_comb begin
        data_data_ok = pop & head_owner;
        inst_data_ok = pop & ~head_owner & ~head_discard & ~inst_cancel;
        data_rdata   = data_data_ok ? rdata : 32'd0;
        inst_rdata   = inst_data_ok ? rdata : 32'd0;
    end

    // FIFO bookkeeping: cancel marks, push, pointers, occupancy, error flag.
    always_comb begin
        owner_d    = owner_q;
        discard_d  = discard_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        resp_err_d = resp_err_q | (data_ok & empty);

        // Marking unoccupied inst slots too is harmless: a push clears the
        // discard bit of the slot it writes.
        if (inst_cancel) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!owner_q[i]) discard_d[i] = 1'b1;
            end
        end

        if (push) begin
            owner_d[wr_ptr_q]   = gnt_data;
            discard_d[wr_ptr_q] = 1'b0;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops all outstanding bookkeeping at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q    <= '0;
            discard_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            resp_err_q <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            discard_q  <= discard_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign resp_err = resp_err_q;

endmodule

// File: doc/cpu_sram_arbiter.md
Name: cpu_sram_arbiter

Overview:
- Shares one SRAM-like memory port between the fetch stage (inst side) and the memory stage (data side).
- Arbitrates address-phase requests and records the owner of each accepted request in an in-order owner FIFO.
- Routes each response (data_ok/rdata) back to its owner.
- Drops inst responses belonging to fetches cancelled by an exception flush, so the flushed pipeline never sees stale instructions.

Parameters:
- DEPTH, 2, maximum outstanding (address-accepted, data-not-returned) transactions; power of 2, ≥1.
- AW, 32, address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch request.
- inst_addr  in  AW  fetch address (read only, size fixed 2'b10).
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch response valid.
- inst_rdata  out  32  fetch data.
- inst_cancel  in  1  one-cycle pulse on exception flush.
- data_req  in  1  memory-stage request.
- data_wr  in  1  1 = store.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_wstrb  in  4  byte enables.
- data_addr  in  AW  data address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  data request accepted.
- data_data_ok  out  1  data response valid.
- data_rdata  out  32  load data.
- req  out  1  shared port request.
- wr  out  1  shared port write.
- size  out  2  shared port size.
- wstrb  out  4  shared port byte enables.
- addr  out  AW  shared port address.
- wdata  out  32  shared port write data.
- addr_ok  in  1  shared port address accepted.
- data_ok  in  1  shared port response.
- rdata  in  32  shared port read data.
- resp_err  out  1  sticky: response arrived with no outstanding transaction.

Behaviour:
- Reset: FIFO empty (count = 0, pointers 0), all discard bits 0, resp_err = 0, rr_last = 0.
- After reset, all *_ok outputs and req are 0 until requests/responses arrive.
- full = (count == DEPTH).
- inst_eligible = inst_req & ~inst_cancel.
- Grant is combinational:
  - gnt_data = data_req & ~full.
  - gnt_inst = inst_eligible & ~full & ~data_req.
  - Fixed data priority.
- Shared outputs:
  - req = gnt_data | gnt_inst.
  - addr/wr/size/wstrb/wdata come from the granted side.
  - On inst grant: wr = 0, size = 2, wstrb = 0, wdata = 0.
  - When there is no grant, the shared outputs are 0.
- Address acceptance:
  - data_addr_ok = gnt_data & addr_ok.
  - inst_addr_ok = gnt_inst & addr_ok.
  - Zero added latency.
- Push on req & addr_ok:
  - owner bit written: 1 = data, 0 = inst.
  - discard bit written 0.
- Pop on data_ok & count != 0, head entry consumed:
  - Head owner data: data_data_ok = 1, data_rdata = rdata, same cycle.
  - Head owner inst, not discarded: inst_data_ok = 1, inst_rdata = rdata.
  - Head owner inst, discarded: response consumed silently; both *_data_ok = 0.
- *_rdata are 0 whenever the corresponding *_data_ok = 0.
- Simultaneous push and pop: count unchanged, both pointers advance. A push into a full FIFO is impossible because req is gated by full.
- A pop in the same cycle frees a slot only from the next cycle; full is evaluated on the current count.
- inst_cancel = 1:
  - Every valid inst entry present that cycle (including the head being popped) gets its discard bit set, effective for responses from the next cycle on.
  - If the head is popped in the cancel cycle, inst_data_ok is still suppressed.
  - Data entries are never discarded.
  - No inst grant occurs in the cancel cycle.
- data_ok while count == 0: ignored (no *_data_ok), resp_err set to 1 and held until reset.
- Pointers wrap modulo DEPTH.
- Reset mid-transaction: all state cleared immediately. Responses for pre-reset requests then hit an empty FIFO and raise resp_err; the system must reset memory simultaneously.

Optional Feature:
- Macro ARB_RR_EN.
- Defined:
  - rr_last register records the side of the last push (1 = data).
  - When both inst_eligible and data_req are set and not full, grant goes to the side other than rr_last.
  - Single requester is granted as usual.
  - rr_last resets to 0, so data wins the first tie.
- Undefined: fixed data priority as above, and rr_last is absent.

Test Plan:
- Single load: data_req = 1, data_addr = 0x1000, addr_ok = 1 at cycle 1, data_ok = 1, rdata = 0xDEADBEEF at cycle 3 → data_addr_ok = 1 at cycle 1, data_data_ok = 1 with data_rdata = 0xDEADBEEF at cycle 3, inst_data_ok stays 0.
- Contention: inst_req and data_req both 1, addr_ok = 1 → data granted first (addr = data_addr), inst at next cycle. Responses in order deliver to data then inst. With ARB_RR_EN, a second tie grants inst.
- Full: DEPTH = 2, two accepted fetches with no data_ok → req = 0 on the third cycle despite inst_req = 1. A data_ok re-enables req the following cycle.
- Cancel: two inst outstanding, inst_cancel pulse, then two data_ok → inst_data_ok never asserts. A new fetch issued afterwards receives its response normally.
- Mixed cancel: queue inst, data, inst; inst_cancel → data response delivered (data_data_ok = 1), both inst responses dropped.
- Spurious response: data_ok = 1 with empty FIFO → resp_err = 1 next cycle and held; reset clears it to 0.
